// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Central pipeline hazard controller for the 5-stage RV32 core
// (IF, ID, EX, MEM, WB).  It arbitrates trap, data-memory wait, multi-cycle
// EX busy, taken branch and load-use hazards into per-stage stall/flush
// vectors and an IF redirect.  A wait FSM tracks MEM/EX waits, and a
// watchdog releases a memory stall that has lasted too long.  Two
// performance counters record stalled and redirected cycles.
//
// Ports
//   clk, rst_n          core clock, asynchronous active-low reset
//   load_use_stall_i    load-use hazard from forwarding unit
//   exe_busy_i          multi-cycle EX op still running
//   mem_req_i           MEM stage has an active data-memory access
//   mem_ready_i         data memory completes the access this cycle
//   branch_taken_i      EX resolved a taken branch/jump
//   branch_target_i     redirect target for branch_taken_i
//   trap_i              MEM stage raises exception/interrupt
//   trap_pc_i           handler address for trap_i
//   stall_o             per-stage hold, bit0=IF ... bit4=WB (combinational)
//   flush_o             per-stage bubble insert, same order (combinational)
//   pc_redirect_o       IF loads new_pc_o this cycle (combinational)
//   new_pc_o            redirect address (combinational)
//   mem_timeout_o       sticky watchdog error flag (registered)
//   stall_cnt_o         cycles with stall_o[0]=1 (registered, wraps)
//   flush_cnt_o         redirects issued (registered, wraps)
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int PC_WIDTH    = 32,
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_use_stall_i,
    input  logic                 exe_busy_i,
    input  logic                 mem_req_i,
    input  logic                 mem_ready_i,
    input  logic                 branch_taken_i,
    input  logic [PC_WIDTH-1:0]  branch_target_i,
    input  logic                 trap_i,
    input  logic [PC_WIDTH-1:0]  trap_pc_i,
    output logic [4:0]           stall_o,
    output logic [4:0]           flush_o,
    output logic                 pc_redirect_o,
    output logic [PC_WIDTH-1:0]  new_pc_o,
    output logic                 mem_timeout_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);

    localparam int WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_EXE_WAIT = 2'd2
    } state_t;

    state_t                r_state;
    logic [WC_W-1:0]       r_wait_cnt;
    logic                  r_mem_timeout;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;
    logic [CNT_WIDTH-1:0]  r_flush_cnt;

    state_t                w_next_state;
    logic [WC_W-1:0]       w_next_wait_cnt;
    logic                  w_mem_pending;
    logic                  w_fire;
    logic                  w_set_timeout;
    logic [4:0]            w_stall;
    logic [4:0]            w_flush;
    logic                  w_redirect;
    logic [PC_WIDTH-1:0]   w_new_pc;

    // Hazard arbitration: trap > mem wait (or watchdog release) > exe busy > branch > load-use
    always_comb begin
        w_mem_pending   = mem_req_i && !mem_ready_i;
        // A trap aborts the wait, so it also pre-empts the watchdog.
        w_fire          = (r_state == ST_MEM_WAIT) && (r_wait_cnt == WC_LAST) &&
                          w_mem_pending && !trap_i;
        w_next_state    = ST_RUN;
        w_next_wait_cnt = {WC_W{1'b0}};
        w_set_timeout   = 1'b0;
        w_stall         = 5'b00000;
        w_flush         = 5'b00000;
        w_redirect      = 1'b0;
        w_new_pc        = {PC_WIDTH{1'b0}};
        if (!rst_n) begin
            // Outputs held at zero during reset regardless of inputs.
            w_next_state = ST_RUN;
        end else if (trap_i) begin
            w_flush    = 5'b01111;
            w_redirect = 1'b1;
            w_new_pc   = trap_pc_i;
        end else if (w_fire) begin
            // Release the pipeline and flag the error; nothing else acts this cycle.
            w_set_timeout = 1'b1;
        end else if (w_mem_pending) begin
            w_stall      = 5'b01111;
            w_flush      = 5'b10000;
            w_next_state = ST_MEM_WAIT;
            // Counting starts on the first cycle spent in MEM_WAIT, so the
            // watchdog allows MEM_TIMEOUT stalled cycles before it fires.
            if (r_state == ST_MEM_WAIT) begin
                w_next_wait_cnt = r_wait_cnt + {{(WC_W-1){1'b0}}, 1'b1};
            end else begin
                w_next_wait_cnt = {WC_W{1'b0}};
            end
        end else if (exe_busy_i) begin
            w_stall      = 5'b00111;
            w_flush      = 5'b01000;
            w_next_state = ST_EXE_WAIT;
        end else if (branch_taken_i) begin
            // Wins over load-use: the dependent younger instruction is flushed.
            w_flush    = 5'b00011;
            w_redirect = 1'b1;
            w_new_pc   = branch_target_i;
        end else if (load_use_stall_i) begin
            w_stall = 5'b00011;
            w_flush = 5'b00100;
        end else begin
            w_next_state = ST_RUN;
        end
    end

    // Wait FSM, watchdog counter, sticky timeout flag and performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= {WC_W{1'b0}};
            r_mem_timeout <= 1'b0;
            r_stall_cnt   <= {CNT_WIDTH{1'b0}};
            r_flush_cnt   <= {CNT_WIDTH{1'b0}};
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_next_wait_cnt;
            if (w_set_timeout) begin
                r_mem_timeout <= 1'b1;
            end else begin
                r_mem_timeout <= r_mem_timeout;
            end
            if (w_stall[0]) begin
                r_stall_cnt <= r_stall_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                r_stall_cnt <= r_stall_cnt;
            end
            if (w_redirect) begin
                r_flush_cnt <= r_flush_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                r_flush_cnt <= r_flush_cnt;
            end
        end
    end

    assign stall_o       = w_stall;
    assign flush_o       = w_flush;
    assign pc_redirect_o = w_redirect;
    assign new_pc_o      = w_new_pc;
    assign mem_timeout_o = r_mem_timeout;
    assign stall_cnt_o   = r_stall_cnt;
    assign flush_cnt_o   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl with MEM_TIMEOUT=4.  Each step drives the
// inputs just after a rising edge, pushes the expected outputs to a
// scoreboard queue, and pops/compares them on the following falling edge.
// Counter expectations come from a running model of stalled/redirect cycles.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int PW = 32;
    localparam int CW = 32;

    logic          clk;
    logic          rst_n;
    logic          load_use_stall_i;
    logic          exe_busy_i;
    logic          mem_req_i;
    logic          mem_ready_i;
    logic          branch_taken_i;
    logic [PW-1:0] branch_target_i;
    logic          trap_i;
    logic [PW-1:0] trap_pc_i;
    logic [4:0]    stall_o;
    logic [4:0]    flush_o;
    logic          pc_redirect_o;
    logic [PW-1:0] new_pc_o;
    logic          mem_timeout_o;
    logic [CW-1:0] stall_cnt_o;
    logic [CW-1:0] flush_cnt_o;

    hazard_ctrl #(.PC_WIDTH(PW), .MEM_TIMEOUT(4), .CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .load_use_stall_i (load_use_stall_i),
        .exe_busy_i       (exe_busy_i),
        .mem_req_i        (mem_req_i),
        .mem_ready_i      (mem_ready_i),
        .branch_taken_i   (branch_taken_i),
        .branch_target_i  (branch_target_i),
        .trap_i           (trap_i),
        .trap_pc_i        (trap_pc_i),
        .stall_o          (stall_o),
        .flush_o          (flush_o),
        .pc_redirect_o    (pc_redirect_o),
        .new_pc_o         (new_pc_o),
        .mem_timeout_o    (mem_timeout_o),
        .stall_cnt_o      (stall_cnt_o),
        .flush_cnt_o      (flush_cnt_o)
    );

    // 10 ns core clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         tag;
        logic [4:0]    st;
        logic [4:0]    fl;
        logic          rd;
        logic [PW-1:0] pc;
        logic          to;
    } exp_t;

    exp_t    sb[$];
    int      checks = 0;
    int      errors = 0;
    int      m_sc   = 0;
    int      m_fc   = 0;
    logic    m_to   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, ".stall_cnt"}, 64'(stall_cnt_o), 64'(m_sc));
        chk({tag, ".flush_cnt"}, 64'(flush_cnt_o), 64'(m_fc));
        chk({tag, ".timeout"},   64'(mem_timeout_o), 64'(m_to));
    endtask

    // One clock of stimulus: drive, push expectation, compare at negedge, advance model.
    task automatic step(input string tag,
                        input logic lu, input logic eb, input logic mr, input logic my,
                        input logic bt, input logic [PW-1:0] bta,
                        input logic tr, input logic [PW-1:0] tpc,
                        input logic [4:0] st, input logic [4:0] fl,
                        input logic rd, input logic [PW-1:0] pc);
        exp_t e;
        load_use_stall_i = lu;
        exe_busy_i       = eb;
        mem_req_i        = mr;
        mem_ready_i      = my;
        branch_taken_i   = bt;
        branch_target_i  = bta;
        trap_i           = tr;
        trap_pc_i        = tpc;
        sb.push_back('{tag, st, fl, rd, pc, m_to});
        @(negedge clk);
        e = sb.pop_front();
        chk({e.tag, ".stall"},  64'(stall_o),       64'(e.st));
        chk({e.tag, ".flush"},  64'(flush_o),       64'(e.fl));
        chk({e.tag, ".redir"},  64'(pc_redirect_o), 64'(e.rd));
        chk({e.tag, ".new_pc"}, 64'(new_pc_o),      64'(e.pc));
        chk({e.tag, ".stall_cnt"}, 64'(stall_cnt_o), 64'(m_sc));
        chk({e.tag, ".flush_cnt"}, 64'(flush_cnt_o), 64'(m_fc));
        chk({e.tag, ".timeout"},   64'(mem_timeout_o), 64'(e.to));
        if (e.st[0]) m_sc++;
        if (e.rd)    m_fc++;
        @(posedge clk);
        #1;
    endtask

    localparam logic [PW-1:0] Z = 32'h0000_0000;

    initial begin
        rst_n = 1'b0;
        load_use_stall_i = 1'b0; exe_busy_i = 1'b0; mem_req_i = 1'b1; mem_ready_i = 1'b0;
        branch_taken_i = 1'b1; branch_target_i = 32'h0000_0040; trap_i = 1'b1; trap_pc_i = 32'h0000_0080;
        #3;
        // Outputs forced to zero under reset even with active inputs.
        chk("rst.stall",  64'(stall_o),       64'd0);
        chk("rst.flush",  64'(flush_o),       64'd0);
        chk("rst.redir",  64'(pc_redirect_o), 64'd0);
        chk("rst.new_pc", 64'(new_pc_o),      64'd0);
        chk_counters("rst");
        mem_req_i = 1'b0; branch_taken_i = 1'b0; trap_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //     tag        lu    eb    mr    my    bt    bta            tr    tpc            stall     flush     rd    pc
        step("idle0",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             5'b00000, 5'b00000, 1'b0, Z);
        step("loaduse",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             5'b00011, 5'b00100, 1'b0, Z);
        step("memw1",    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Z,             1'b0, Z,             5'b01111, 5'b10000, 1'b0, Z);
        step("memw2",    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Z,             1'b0, Z,             5'b01111, 5'b10000, 1'b0, Z);
        step("memw3",    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Z,             1'b0, Z,             5'b01111, 5'b10000, 1'b0, Z);
        step("memrdy",   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, Z,             1'b0, Z,             5'b00000, 5'b00000, 1'b0, Z);
        step("idle1",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             5'b00000, 5'b00000, 1'b0, Z);

        // Watchdog: four stalled cycles, fifth is released and sets the flag.
        for (int i = 0; i < 4; i++)
            step("wd_stall", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Z,         1'b0, Z,             5'b01111, 5'b10000, 1'b0, Z);
        step("wd_fire",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Z,             1'b0, Z,             5'b00000, 5'b00000, 1'b0, Z);
        m_to = 1'b1;
        step("wd_stick", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             5'b00000, 5'b00000, 1'b0, Z);

        // Branch held behind exe busy, taken once busy drops.
        step("eb_br1",   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, Z,             5'b00111, 5'b01000, 1'b0, Z);
        step("eb_br2",   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, Z,             5'b00111, 5'b01000, 1'b0, Z);
        step("br_go",    1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, Z,             5'b00000, 5'b00011, 1'b1, 32'h0000_0100);
        step("br_lu",    1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, Z,             5'b00000, 5'b00011, 1'b1, 32'h0000_0200);

        // Trap aborts a MEM wait; the watchdog count restarts afterwards.
        step("tw_mem1",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Z,             1'b0, Z,             5'b01111, 5'b10000, 1'b0, Z);
        step("tw_mem2",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Z,             1'b0, Z,             5'b01111, 5'b10000, 1'b0, Z);
        step("trap",     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, Z,             1'b1, 32'h8000_0000, 5'b00000, 5'b01111, 1'b1, 32'h8000_0000);
        for (int i = 0; i < 4; i++)
            step("tr_stall", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Z,         1'b0, Z,             5'b01111, 5'b10000, 1'b0, Z);
        step("tr_fire",  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Z,             1'b0, Z,             5'b00000, 5'b00000, 1'b0, Z);

        // Asynchronous reset in the middle of a MEM wait.
        step("ar_mem",   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, Z,             1'b0, Z,             5'b01111, 5'b10000, 1'b0, Z);
        #2;
        rst_n = 1'b0;
        #1;
        m_sc = 0;
        m_fc = 0;
        m_to = 1'b0;
        chk("ar.stall",  64'(stall_o),       64'd0);
        chk("ar.flush",  64'(flush_o),       64'd0);
        chk("ar.redir",  64'(pc_redirect_o), 64'd0);
        chk_counters("ar");
        mem_req_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             5'b00011, 5'b00100, 1'b0, Z);
        step("idle2",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, Z,             1'b0, Z,             5'b00000, 5'b00000, 1'b0, Z);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
